// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island constants: packet type codes, IEC60958 frame count
// and the audio sample packet layout selector.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_SPD   = 8'h83;
  localparam logic [7:0] PKT_AINFO = 8'h84;

  localparam int IEC_FRAMES = 192;

  typedef enum logic {
    LAYOUT_2CH = 1'b0,
    LAYOUT_8CH = 1'b1
  } layout_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Multichannel audio sample FIFO with a parallel look-ahead read of up to
// RD_PORTS entries and a variable pop of 0..4 entries per cycle.
module audio_sample_fifo #(
  parameter int WIDTH    = 48,
  parameter int DEPTH    = 8,
  parameter int RD_PORTS = 4,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic [2:0]                    pop,
  output logic                          full,
  output logic [CW-1:0]                 count,
  output logic [RD_PORTS-1:0][WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_acc;

  assign full     = (count == CW'(DEPTH));
  assign push_acc = push && !full;

  // The caller never pops more than count, so pop only sees entries present before the edge
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_acc) - CW'(pop);
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) rd_data[i] = mem[rd_ptr + PW'(i)];
  end

endmodule

// File: rtl/packet_scheduler.sv
// HDMI data-island packet scheduler: arbitrates ACR, audio sample, InfoFrame
// and null packets, packing queued audio samples in layout 0 or layout 1.
module packet_scheduler import hdmi_packet_pkg::*; #(
  parameter int                          AUDIO_BIT_WIDTH  = 24,
  parameter int                          NUM_CHANNELS     = 2,
  parameter int                          FIFO_DEPTH       = 8,
  parameter int                          NUM_INFOFRAMES   = 3,
  parameter logic [8*NUM_INFOFRAMES-1:0] INFOFRAME_TYPES  = {PKT_SPD, PKT_AVI, PKT_AINFO},
  parameter int                          INFOFRAME_PERIOD = 1
) (
  input  logic                                    clk_pixel,
  input  logic                                    reset_n,
  input  logic                                    video_field_end,
  input  logic                                    packet_enable,
  input  logic [4:0]                              packet_pixel_counter,
  input  logic                                    acr_wrap,
  input  logic                                    sample_valid,
  output logic                                    sample_ready,
  input  logic [NUM_CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_word,
  output logic [7:0]                              packet_type,
  output logic [191:0]                            audio_sample_word_packet,
  output logic [3:0]                              audio_sample_word_present_packet,
  output logic                                    layout,
  output logic [7:0]                              frame_counter
);

  localparam layout_e LAYOUT   = (NUM_CHANNELS == 8) ? LAYOUT_8CH : LAYOUT_2CH;
  localparam int      SW       = NUM_CHANNELS * AUDIO_BIT_WIDTH;
  localparam int      CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int      RD_PORTS = (LAYOUT == LAYOUT_8CH) ? 1 : 4;

  function automatic logic [23:0] pad24(input logic [AUDIO_BIT_WIDTH-1:0] s);
    return 24'(s) << (24 - AUDIO_BIT_WIDTH);
  endfunction

  function automatic logic [7:0] frame_advance(input logic [7:0] fc, input logic [2:0] n);
    logic [8:0] s;
    s = {1'b0, fc} + {6'b0, n};
    if (s >= 9'(IEC_FRAMES)) s = s - 9'(IEC_FRAMES);
    return s[7:0];
  endfunction

  logic                         fifo_full;
  logic [CW-1:0]                fifo_count;
  logic [RD_PORTS-1:0][SW-1:0]  fifo_rd;
  logic [2:0]                   avail_n_p0;
  logic [2:0]                   pop_p0;
  logic [191:0]                 payload_p0;
  logic [3:0]                   present_p0;
  logic                         acr_due_p0;
  logic                         audio_sel_p0;
  logic                         if_hit_p0;
  logic [NUM_INFOFRAMES-1:0]    if_mask_p0;
  logic [7:0]                   if_type_p0;

  logic [191:0]                 payload_p1;
  logic [3:0]                   present_p1;
  logic                         last_acr;
  logic [NUM_INFOFRAMES-1:0]    pending_q;
  logic [7:0]                   field_cnt_q;
  logic [2:0]                   last_n_q;

  audio_sample_fifo #(
    .WIDTH    (SW),
    .DEPTH    (FIFO_DEPTH),
    .RD_PORTS (RD_PORTS)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .push      (sample_valid),
    .push_data (sample_word),
    .pop       (pop_p0),
    .full      (fifo_full),
    .count     (fifo_count),
    .rd_data   (fifo_rd)
  );

  assign sample_ready = !fifo_full;
  assign layout       = LAYOUT;

  // Stage p0: decision inputs and combinational payload packing
  assign acr_due_p0   = (acr_wrap != last_acr);
  assign audio_sel_p0 = packet_enable && !video_field_end && !acr_due_p0 && (fifo_count != '0);
  assign pop_p0       = audio_sel_p0 ? avail_n_p0 : 3'd0;

  if (LAYOUT == LAYOUT_2CH) begin : g_layout0
    assign avail_n_p0 = (fifo_count >= CW'(4)) ? 3'd4 : 3'(fifo_count);
    always_comb begin
      payload_p0 = '0;
      present_p0 = '0;
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < avail_n_p0) begin
          payload_p0[48*i +: 24]    = pad24(fifo_rd[i][0 +: AUDIO_BIT_WIDTH]);
          payload_p0[48*i+24 +: 24] = pad24(fifo_rd[i][AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
          present_p0[i]             = 1'b1;
        end
      end
    end
  end else begin : g_layout1
    assign avail_n_p0 = (fifo_count != '0) ? 3'd1 : 3'd0;
    always_comb begin
      payload_p0 = '0;
      present_p0 = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        payload_p0[48*i +: 24]    = pad24(fifo_rd[0][2*i*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
        payload_p0[48*i+24 +: 24] = pad24(fifo_rd[0][(2*i+1)*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]);
      end
    end
  end

  // Lowest pending index wins, so scan from the top and let the last hit stand
  always_comb begin
    if_hit_p0  = 1'b0;
    if_mask_p0 = '0;
    if_type_p0 = PKT_NULL;
    for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        if_hit_p0  = 1'b1;
        if_mask_p0 = NUM_INFOFRAMES'(1) << i;
        if_type_p0 = INFOFRAME_TYPES[8*i +: 8];
      end
    end
  end

  // Stage p1: registered decision; field end drops any simultaneous request
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      packet_type <= PKT_NULL;
      payload_p1  <= '0;
      present_p1  <= '0;
      last_acr    <= 1'b0;
      pending_q   <= '1;
      field_cnt_q <= '0;
      last_n_q    <= '0;
    end else if (video_field_end) begin
      packet_type <= PKT_NULL;
      if (field_cnt_q == 8'(INFOFRAME_PERIOD - 1)) begin
        field_cnt_q <= '0;
        pending_q   <= '1;
      end else begin
        field_cnt_q <= field_cnt_q + 8'd1;
      end
    end else if (packet_enable) begin
      if (acr_due_p0) begin
        packet_type <= PKT_ACR;
        last_acr    <= acr_wrap;
      end else if (audio_sel_p0) begin
        packet_type <= PKT_AUDIO;
        payload_p1  <= payload_p0;
        present_p1  <= present_p0;
        last_n_q    <= avail_n_p0;
      end else if (if_hit_p0) begin
        packet_type <= if_type_p0;
        pending_q   <= pending_q & ~if_mask_p0;
      end else begin
        packet_type <= PKT_NULL;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      frame_counter <= '0;
    end else if (packet_pixel_counter == 5'd31 && packet_type == PKT_AUDIO) begin
      frame_counter <= frame_advance(frame_counter, last_n_q);
    end
  end

  assign audio_sample_word_packet         = payload_p1;
  assign audio_sample_word_present_packet = present_p1;

endmodule
